// File: rtl/disk_batch_ctrl.sv
// Batch controller: walks a run of sequence indices through a single-issue disk
// engine and streams each captured result out over a valid/ready beat interface.
module disk_batch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_k0,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [1:0]       cmd_base0,
  input  logic [1:0]       cmd_base1,
  input  logic             abort,
  output logic             eng_start,
  output logic [31:0]      eng_k,
  output logic [1:0]       eng_base_sel0,
  output logic [1:0]       eng_base_sel1,
  input  logic             eng_ready,
  input  logic             eng_done,
  input  logic [31:0]      eng_x,
  input  logic [31:0]      eng_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic [31:0]      out_k,
  output logic             out_last,
  output logic             busy,
  output logic             batch_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      k_q, k_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       base0_q, base0_d;
  logic [1:0]       base1_q, base1_d;
  logic [31:0]      ox_q, ox_d;
  logic [31:0]      oy_q, oy_d;
  logic [31:0]      ok_q, ok_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      rem_q   <= '0;
      base0_q <= '0;
      base1_q <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ok_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      base0_q <= base0_d;
      base1_q <= base1_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
    end
  end

  // remaining is cleared on every return to IDLE so out_last cannot linger.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    base0_d = base0_q;
    base1_d = base1_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          k_d     = cmd_k0;
          rem_d   = cmd_count;
          base0_d = cmd_base0;
          base1_d = cmd_base1;
          if (cmd_count != '0) state_d = S_ISSUE;
          else                 done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else if (eng_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          // A result arriving with the abort is already the one DRAIN would discard.
          state_d = eng_done ? S_IDLE : S_DRAIN;
          rem_d   = '0;
        end else if (eng_done) begin
          ox_d    = eng_x;
          oy_d    = eng_y;
          ok_d    = k_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready && rem_q > CNT_W'(1)) begin
          k_d     = k_q + 32'd1;
          rem_d   = rem_q - CNT_W'(1);
          state_d = S_ISSUE;
        end else if (out_ready) begin
          rem_d   = '0;
          state_d = S_IDLE;
          done_d  = !abort;
        end
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end
      end
      S_DRAIN: begin
        if (eng_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    eng_start     = (state_q == S_ISSUE) && eng_ready && !abort;
    out_valid     = (state_q == S_OUT);
    out_last      = (rem_q == CNT_W'(1));
    eng_k         = k_q;
    eng_base_sel0 = base0_q;
    eng_base_sel1 = base1_q;
    out_x         = ox_q;
    out_y         = oy_q;
    out_k         = ok_q;
    batch_done    = done_q;
  end

endmodule

// File: tb/tb_disk_batch_ctrl.sv
// Self-checking bench for disk_batch_ctrl: table-driven and randomized batches
// against a queue-based beat model, plus abort and reset corner sequences.
module tb_disk_batch_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_k0 = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [1:0]       cmd_base0 = '0;
  logic [1:0]       cmd_base1 = '0;
  logic             abort = 1'b0;
  logic             eng_start;
  logic [31:0]      eng_k;
  logic [1:0]       eng_base_sel0, eng_base_sel1;
  logic             eng_ready;
  logic             eng_done = 1'b0;
  logic [31:0]      eng_x = '0, eng_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_x, out_y, out_k;
  logic             out_last, busy, batch_done;

  disk_batch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k0(cmd_k0), .cmd_count(cmd_count),
    .cmd_base0(cmd_base0), .cmd_base1(cmd_base1), .abort(abort),
    .eng_start(eng_start), .eng_k(eng_k), .eng_base_sel0(eng_base_sel0),
    .eng_base_sel1(eng_base_sel1), .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_x(eng_x), .eng_y(eng_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_k(out_k), .out_last(out_last),
    .busy(busy), .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Engine model: fixed latency, x = k, y = ~k; independent of DUT reset.
  logic        e_busy = 1'b0;
  int          e_cnt = 0;
  logic [31:0] e_k = '0;
  int          eng_lat = 20;
  logic        eng_hold = 1'b0;
  int          starts = 0;
  logic [1:0]  exp_b0 = '0, exp_b1 = '0;

  assign eng_ready = !e_busy && !eng_hold;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_start) begin
      starts++;
      chk("start_when_ready", 32'(eng_ready), 32'd1);
      chk("eng_base_sel0", 32'(eng_base_sel0), 32'(exp_b0));
      chk("eng_base_sel1", 32'(eng_base_sel1), 32'(exp_b1));
    end
    if (e_busy) begin
      if (e_cnt <= 1) begin
        eng_done <= 1'b1;
        eng_x    <= e_k;
        eng_y    <= ~e_k;
        e_busy   <= 1'b0;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end else if (eng_start) begin
      e_busy <= 1'b1;
      e_cnt  <= eng_lat;
      e_k    <= eng_k;
    end
  end

  // Sink: random or steady ready, or manual when the main sequence owns it.
  bit rnd_ready = 1'b0;
  bit manual = 1'b0;
  always @(negedge clk) begin
    if (!manual) out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct {
    logic [31:0] k;
    logic [31:0] x;
    logic [31:0] y;
    logic        last;
  } beat_t;
  beat_t beats[$];
  int    dones = 0;
  bit    stalled = 1'b0;
  beat_t held;

  always @(posedge clk) begin
    beat_t b;
    b.k = out_k; b.x = out_x; b.y = out_y; b.last = out_last;
    if (stalled && out_valid) begin
      chk("stall_k", out_k, held.k);
      chk("stall_x", out_x, held.x);
      chk("stall_y", out_y, held.y);
      chk("stall_last", 32'(out_last), 32'(held.last));
    end
    if (out_valid && out_ready) beats.push_back(b);
    if (batch_done) dones++;
    stalled = out_valid && !out_ready;
    held = b;
  end

  task automatic send(input logic [31:0] k0, input int cnt, input logic [1:0] b0, input logic [1:0] b1);
    int t = 0;
    while (busy && t < 2000) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_k0 = k0; cmd_count = CNT_W'(cnt);
    cmd_base0 = b0; cmd_base1 = b1; exp_b0 = b0; exp_b1 = b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // Reference: batch of n beats is k0+i (mod 2^32), x = k, y = ~k, last on i = n-1.
  task automatic run_check(input string tag, input logic [31:0] k0, input int cnt,
                           input bit rnd, input int lat, input logic [1:0] b0, input logic [1:0] b1);
    int s0, d0, t;
    logic [31:0] ek;
    beats.delete();
    rnd_ready = rnd; eng_lat = lat;
    s0 = starts; d0 = dones;
    send(k0, cnt, b0, b1);
    t = 0;
    while (dones == d0 && t < 5000) begin @(negedge clk); t++; end
    chk({tag, "_done_timeout"}, 32'(dones > d0), 32'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_beats"}, 32'(beats.size()), 32'(cnt));
    chk({tag, "_starts"}, 32'(starts - s0), 32'(cnt));
    chk({tag, "_batch_done"}, 32'(dones - d0), 32'd1);
    for (int i = 0; i < beats.size() && i < cnt; i++) begin
      ek = k0 + 32'(i);
      chk($sformatf("%s_k%0d", tag, i), beats[i].k, ek);
      chk($sformatf("%s_x%0d", tag, i), beats[i].x, ek);
      chk($sformatf("%s_y%0d", tag, i), beats[i].y, ~ek);
      chk($sformatf("%s_last%0d", tag, i), 32'(beats[i].last), 32'(i == cnt - 1));
    end
    rnd_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] k0;
    int          count;
    bit          rnd;
    int          lat;
    int          exp_beats;
    logic [31:0] exp_last_k;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, nb, t;
    vecs[0] = '{32'd1,          5, 1'b0, 20, 5, 32'd5};
    vecs[1] = '{32'd1,          5, 1'b1, 20, 5, 32'd5};
    vecs[2] = '{32'd0,          0, 1'b0, 20, 0, 32'd0};
    vecs[3] = '{32'hFFFFFFFE,   3, 1'b1, 3,  3, 32'h00000000};
    vecs[4] = '{32'h7FFFFFFF,   1, 1'b1, 2,  1, 32'h7FFFFFFF};
    vecs[5] = '{32'h12345678,   2, 1'b0, 1,  2, 32'h12345679};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_batch_done", 32'(batch_done), 32'd0);
    chk("rst_out_k", out_k, 32'd0);
    chk("rst_eng_k", eng_k, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].k0, vecs[i].count, vecs[i].rnd, vecs[i].lat,
                (i == 0) ? 2'd0 : 2'($urandom_range(0, 3)), (i == 0) ? 2'd1 : 2'($urandom_range(0, 3)));
      chk($sformatf("vec%0d_nbeats", i), 32'(beats.size()), 32'(vecs[i].exp_beats));
      if (vecs[i].exp_beats > 0 && beats.size() > 0)
        chk($sformatf("vec%0d_lastk", i), beats[beats.size()-1].k, vecs[i].exp_last_k);
    end

    for (int i = 0; i < 6; i++)
      run_check($sformatf("rnd%0d", i), $urandom, int'($urandom_range(1, 6)), 1'b1,
                int'($urandom_range(1, 8)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // count = 0: done pulse exactly one cycle after acceptance, never busy.
    s0 = starts;
    send(32'd9, 0, 2'd0, 2'd0);
    chk("zero_done_pulse", 32'(batch_done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_done_single", 32'(batch_done), 32'd0);
    chk("zero_no_start", 32'(starts - s0), 32'd0);

    // Abort while waiting on beat 2: drain the result, no beat, no batch_done.
    beats.delete(); eng_lat = 20; s0 = starts; d0 = dones;
    send(32'd10, 4, 2'd2, 2'd3);
    t = 0;
    while (starts - s0 < 2 && t < 500) begin @(negedge clk); t++; end
    chk("abw_reach_wait", 32'(starts - s0), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abw_drain_busy", 32'(busy), 32'd1);
    wait_idle("abw");
    chk("abw_engine_drained", 32'(e_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abw_beats", 32'(beats.size()), 32'd1);
    chk("abw_no_done", 32'(dones - d0), 32'd0);
    chk("abw_starts", 32'(starts - s0), 32'd2);
    run_check("after_abw", 32'd100, 3, 1'b0, 5, 2'd1, 2'd2);

    // Abort in ISSUE while engine not ready: no start even as ready rises.
    eng_hold = 1'b1; s0 = starts; d0 = dones;
    send(32'd50, 3, 2'd0, 2'd0);
    chk("abi_busy", 32'(busy), 32'd1);
    abort = 1'b1; eng_hold = 1'b0;
    #1;
    chk("abi_no_start", 32'(eng_start), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    chk("abi_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abi_starts", 32'(starts - s0), 32'd0);
    chk("abi_no_done", 32'(dones - d0), 32'd0);

    // Abort in OUT with a same-cycle handshake: beat delivered, no batch_done.
    manual = 1'b1; out_ready = 1'b0; beats.delete(); eng_lat = 4; d0 = dones;
    send(32'd70, 3, 2'd0, 2'd0);
    t = 0;
    while (!out_valid && t < 500) begin @(negedge clk); t++; end
    chk("abo_out_valid", 32'(out_valid), 32'd1);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk("abo_dropped", 32'(out_valid), 32'd0);
    chk("abo_idle", 32'(busy), 32'd0);
    chk("abo_beats", 32'(beats.size()), 32'd1);
    repeat (2) @(negedge clk);
    chk("abo_no_done", 32'(dones - d0), 32'd0);

    // Reset during OUT of beat 3.
    beats.delete(); out_ready = 1'b1; eng_lat = 20;
    send(32'd200, 5, 2'd3, 2'd3);
    t = 0;
    while (beats.size() < 2 && t < 500) begin @(negedge clk); t++; end
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 500) begin @(negedge clk); t++; end
    chk("rso_in_out", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rso_out_valid", 32'(out_valid), 32'd0);
    chk("rso_busy", 32'(busy), 32'd0);
    chk("rso_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rso_out_k", out_k, 32'd0);
    chk("rso_out_x", out_x, 32'd0);
    chk("rso_out_y", out_y, 32'd0);
    chk("rso_eng_k", eng_k, 32'd0);
    chk("rso_out_last", 32'(out_last), 32'd0);
    chk("rso_sel", 32'({eng_base_sel0, eng_base_sel1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Reset while engine is busy: its late result must not become a beat.
    nb = beats.size();
    send(32'd300, 2, 2'd0, 2'd0);
    t = 0;
    while (!e_busy && t < 100) begin @(negedge clk); t++; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (e_busy && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("rsw_no_beat", 32'(beats.size()), 32'(nb));
    chk("rsw_out_valid", 32'(out_valid), 32'd0);
    chk("rsw_busy", 32'(busy), 32'd0);
    manual = 1'b0;
    run_check("after_rst", 32'd5, 2, 1'b1, 3, 2'd1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
